arb_mux_n: RTL and testbench
============================

// Module: arb_mux_n
// PURPOSE
//  Parametrised N-input, WIDTH-bit selector with a registered output and valid/ready handshakes.
//  Replaces fixed 4:1 combinational selects wherever several producers share one consumer.
//  Two select modes:
//   - explicit sel: multicycle datapath operand and writeback selection.
//   - round-robin: arbitration between competing requesters, e.g. fetch and load/store to memory.
// PARAMETERS
//  WIDTH  32          data width per channel
//  N      4           number of input channels, 2..16
//  SELW   $clog2(N)   select/source-index width (derived; do not override)
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst_n      in   1        reset: synchronous, active-low
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel request
//  in_ready   out  N        per-channel accept (combinational)
//  mode       in   1        0 = explicit select via sel; 1 = round-robin
//  sel        in   SELW     channel index used when mode=0
//  out_data   out  WIDTH    registered selected data
//  out_src    out  SELW     registered index of the channel that supplied out_data
//  out_valid  out  1        output register holds a beat
//  out_ready  in   1        consumer accept
//  lock       in   1        only with ARB_MUX_LOCK_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_src=0, rr_ptr=0, lock state cleared.
//  Output stage:
//   - Single-entry output register.
//   - can_load = ~out_valid | out_ready.
//  Grant (combinational, at most one bit set):
//   - mode=0: grant[sel] = in_valid[sel].
//   - mode=0, sel>=N: no grant, all in_ready=0.
//   - mode=1: first i with in_valid[i], scanning from rr_ptr upward modulo N (wraps N-1 -> 0).
//  Handshake:
//   - in_ready[i] = grant[i] & can_load.
//   - Transfer on channel i when in_valid[i] & in_ready[i].
//   - On transfer: out_data<=in_data[i], out_src<=i, out_valid<=1.
//  Latency: exactly 1 cycle from accepted input to out_valid.
//   - Full throughput: one beat per cycle when out_ready is held high.
//  Drain: out_valid & out_ready & no transfer -> out_valid<=0.
//   - out_data and out_src hold their last values.
//  Stall: out_valid & ~out_ready -> out_data and out_src held stable, all in_ready=0.
//  Round-robin pointer:
//   - On every transfer in mode=1, rr_ptr <= (granted index + 1) mod N.
//   - Unchanged in mode=0 and on cycles with no transfer.
//  Simultaneous drain+load in the same cycle: new beat loaded and out_valid stays 1.
//  Mode or sel change: affects only the next grant decision; a beat already held is unaffected.
//  No in_valid set: no grant, output register behaves per drain/stall rules.
//  Reset mid-transfer: any held beat is discarded and out_valid=0 on the next cycle.
//  Uncaptured inputs: producers must hold in_data and in_valid until accepted.
//   - The block does not capture any beat that was not granted.
// CONFIGURATION
//  ARB_MUX_LOCK_EN defined:
//   - lock port present.
//   - A transfer with lock=1 sets locked=1 and lock_idx=granted index.
//   - While locked: grant is restricted to lock_idx in both modes; rr_ptr does not advance.
//   - Any transfer with lock=0 clears locked after it completes.
//   - Reset clears locked.
//  ARB_MUX_LOCK_EN undefined:
//   - No lock port, no lock state.
//   - Grant is exactly as described in BEHAVIOUR.
// TESTING
//  Reset: rst_n=0 two cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout.
//  Explicit select:
//   - Stimulus: mode=0, sel=2, in_data ch2=32'hDEAD_BEEF, all valid, out_ready=1.
//   - Response: in_ready=4'b0100; next cycle out_data=DEADBEEF, out_src=2.
//  Round-robin fairness:
//   - Stimulus: mode=1, all 4 valid for 8 cycles, out_ready=1.
//   - Response: out_src sequence 0,1,2,3,0,1,2,3 with no idle cycles.
//  Backpressure:
//   - Stimulus: out_ready=0 while out_valid=1 with ch1=32'h1111_1111 held.
//   - Response: out_data stable, in_ready=0.
//   - Then raise out_ready: drain and new load in the same cycle, out_valid stays 1.
//  Wrap and sparse requests:
//   - Stimulus: mode=1, rr_ptr=3, in_valid=4'b0011.
//   - Response: ch0 granted; rr_ptr becomes 1, so ch1 is granted next.
//  Lock (ARB_MUX_LOCK_EN):
//   - Stimulus: ch2 transfers with lock=1, then all channels valid.
//   - Response: only ch2 is granted until a transfer with lock=0; round-robin then resumes at ch3.

Source files
------------

// File: rtl/arb_mux_n.sv
// -----------------------------------------------------------------------------
// arb_mux_n
//
// Purpose
//   N-input, WIDTH-bit selector with a single-entry registered output and
//   valid/ready handshakes on both sides. Two select modes:
//     mode=0 : explicit select, channel chosen by sel
//     mode=1 : round-robin arbitration, scanning upward from rr_ptr
//
// Parameters
//   WIDTH  data width per channel
//   N      number of input channels (2..16)
//   SELW   select/source-index width, derived from N (do not override)
//
// Ports
//   clk        in   1        clock, all state updates on rising edge
//   rst_n      in   1        synchronous active-low reset
//   in_data    in   N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel request
//   in_ready   out  N        per-channel accept (combinational)
//   mode       in   1        0 = explicit select, 1 = round-robin
//   sel        in   SELW     channel index used when mode=0
//   out_data   out  WIDTH    registered selected data
//   out_src    out  SELW     registered index of the supplying channel
//   out_valid  out  1        output register holds a beat
//   out_ready  in   1        consumer accept
//   lock       in   1        present only when ARB_MUX_LOCK_EN is defined
//
// Configuration
//   ARB_MUX_LOCK_EN : when defined, adds the lock port and lock state. A
//   transfer with lock=1 pins the grant to that channel (in both modes) until
//   a transfer with lock=0 completes; rr_ptr is frozen while locked.
// -----------------------------------------------------------------------------
module arb_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    output logic               out_valid,
    input  logic               out_ready
`ifdef ARB_MUX_LOCK_EN
    ,
    input  logic               lock
`endif
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Increment a channel index, wrapping N-1 back to 0.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
        int t;
        t = int'(v) + 1;
        if (t >= N) begin
            t = 0;
        end else begin
            t = t;
        end
        return t[SELW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

`ifdef ARB_MUX_LOCK_EN
    logic             locked_q,    locked_d;
    logic [SELW-1:0]  lock_idx_q,  lock_idx_d;
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             can_load_s;
    logic             accept_en_s;
    logic [31:0]      sel_ext_s;
    logic             rr_hit_s;
    logic [SELW-1:0]  rr_idx_s;
    logic [N-1:0]     grant_s;
    logic             gnt_any_s;
    logic [SELW-1:0]  gnt_idx_s;
    logic [WIDTH-1:0] gnt_data_s;
    logic             xfer_s;
    logic             rr_adv_s;

    assign can_load_s  = ~out_valid_q | out_ready;
    // Nothing is accepted while reset is asserted: such a beat would be
    // discarded by the reset anyway, so the producer must keep it.
    assign accept_en_s = can_load_s & rst_n;
    assign sel_ext_s   = {{(32-SELW){1'b0}}, sel};

    // Round-robin search: first requesting channel at or after rr_ptr, modulo N.
    always_comb begin
        int pos;
        rr_hit_s = 1'b0;
        rr_idx_s = {SELW{1'b0}};
        pos      = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= N) begin
                pos = pos - N;
            end else begin
                pos = pos;
            end
            if (!rr_hit_s && in_valid[pos]) begin
                rr_hit_s = 1'b1;
                rr_idx_s = pos[SELW-1:0];
            end else begin
                rr_hit_s = rr_hit_s;
            end
        end
    end

    // One-hot grant vector from the active select policy.
    always_comb begin
        grant_s = {N{1'b0}};
`ifdef ARB_MUX_LOCK_EN
        if (locked_q) begin
            // Locked: only the owning channel may be granted, whatever the mode.
            for (int i = 0; i < N; i++) begin
                if (int'(lock_idx_q) == i) begin
                    grant_s[i] = in_valid[i];
                end else begin
                    grant_s[i] = 1'b0;
                end
            end
        end else
`endif
        if (mode == 1'b0) begin
            // Explicit select; an out-of-range sel matches no channel.
            for (int i = 0; i < N; i++) begin
                if (sel_ext_s == 32'(i)) begin
                    grant_s[i] = in_valid[i];
                end else begin
                    grant_s[i] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rr_hit_s && (int'(rr_idx_s) == i)) begin
                    grant_s[i] = 1'b1;
                end else begin
                    grant_s[i] = 1'b0;
                end
            end
        end
    end

    // Encode the one-hot grant into an index and pick the granted data.
    always_comb begin
        gnt_idx_s  = {SELW{1'b0}};
        gnt_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant_s[i]) begin
                gnt_idx_s  = i[SELW-1:0];
                gnt_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                gnt_idx_s  = gnt_idx_s;
            end
        end
    end

    assign gnt_any_s = |grant_s;
    assign in_ready  = grant_s & {N{accept_en_s}};
    assign xfer_s    = gnt_any_s & accept_en_s;

`ifdef ARB_MUX_LOCK_EN
    assign rr_adv_s  = xfer_s & mode & ~locked_q;
`else
    assign rr_adv_s  = xfer_s & mode;
`endif

    // Next-state for the output register, round-robin pointer and lock state.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer_s) begin
            // Covers both a plain load and a same-cycle drain+load.
            out_data_d  = gnt_data_s;
            out_src_d   = gnt_idx_s;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            // Drain: data and source keep their last values.
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (rr_adv_s) begin
            rr_ptr_d = wrap_inc(gnt_idx_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    // Lock ownership follows the lock flag of each completed transfer.
    always_comb begin
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (xfer_s) begin
            locked_d = lock;
            if (lock) begin
                lock_idx_d = gnt_idx_s;
            end else begin
                lock_idx_d = lock_idx_q;
            end
        end else begin
            locked_d = locked_q;
        end
    end
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= {WIDTH{1'b0}};
            out_src_q   <= {SELW{1'b0}};
            out_valid_q <= 1'b0;
            rr_ptr_q    <= {SELW{1'b0}};
`ifdef ARB_MUX_LOCK_EN
            locked_q    <= 1'b0;
            lock_idx_q  <= {SELW{1'b0}};
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_MUX_LOCK_EN
            locked_q    <= locked_d;
            lock_idx_q  <= lock_idx_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_n
//
// Self-checking bench for arb_mux_n (default build, WIDTH=32, N=4).
// Directed scenarios for reset, explicit select, round-robin order,
// backpressure and wrap, followed by randomized traffic compared against a
// cycle-level reference model of the selector's rules.
// -----------------------------------------------------------------------------
module tb_arb_mux_n;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk;
    logic               rst_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_src   = 0;
    int               m_rr    = 0;

    arb_mux_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model grant: the requesting channel with the smallest forward distance
    // from the round-robin pointer, or the selected channel in explicit mode.
    function automatic int model_grant();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) best = int'(sel);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i]) begin
                    d = (i - m_rr + N) % N;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
        end
        return best;
    endfunction

    // One clock cycle with the currently driven inputs: check the
    // combinational accepts, advance the model, then check the registers.
    task automatic step();
        int g;
        logic [N-1:0] er;
        #1;
        g  = model_grant();
        er = '0;
        if (rst_n && g >= 0 && (!m_valid || out_ready)) er[g] = 1'b1;
        chk("in_ready", {60'd0, in_ready}, {60'd0, er});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_rr    = 0;
        end else if (er != '0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_src   = g;
            if (mode) m_rr = (g + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("out_data",  {32'd0, out_data},  {32'd0, m_data});
        chk("out_src",   {62'd0, out_src},   64'(m_src));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
        @(negedge clk);

        // Reset with every channel requesting
        do_reset();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data",  {32'd0, out_data},  64'd0);

        // Explicit select of channel 2
        mode = 1'b0;
        sel  = 2'd2;
        in_data[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        #1 chk("sel_ready", {60'd0, in_ready}, 64'h4);
        step();
        chk("sel_data", {32'd0, out_data}, 64'hDEAD_BEEF);
        chk("sel_src",  {62'd0, out_src},  64'd2);

        // Round-robin fairness from a fresh pointer
        do_reset();
        mode = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_src",   {62'd0, out_src},   64'(k % 4));
            chk("rr_valid", {63'd0, out_valid}, 64'd1);
        end

        // Backpressure holding a channel-1 beat
        mode = 1'b0;
        sel  = 2'd1;
        in_data[1*WIDTH +: WIDTH] = 32'h1111_1111;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data[1*WIDTH +: WIDTH] = 32'h2222_2222;
            #1 chk("bp_ready", {60'd0, in_ready}, 64'd0);
            step();
            chk("bp_data", {32'd0, out_data}, 64'h1111_1111);
        end
        out_ready = 1'b1;
        step();
        chk("bp_reload_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_reload_data",  {32'd0, out_data},  64'h2222_2222);

        // Wrap: a channel-2 transfer leaves the pointer at 3, then sparse requests
        mode = 1'b1;
        in_valid = 4'b0100;
        step();
        in_valid = 4'b0011;
        #1 chk("wrap_ready0", {60'd0, in_ready}, 64'h1);
        step();
        chk("wrap_src0", {62'd0, out_src}, 64'd0);
        #1 chk("wrap_ready1", {60'd0, in_ready}, 64'h2);
        step();
        chk("wrap_src1", {62'd0, out_src}, 64'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            r = $urandom;
            in_valid  = r[3:0];
            mode      = r[4];
            sel       = r[6:5];
            out_ready = (r[9:7] != 3'd0);
            rst_n     = (r[15:10] != 6'd0);
            for (int i = 0; i < N; i++) begin
                if (r[16+i]) in_data[i*WIDTH +: WIDTH] = $urandom;
            end
            step();
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
